fd4_write_arbiter: RTL and testbench

Write-port arbiter for a shared 4-bit clock-enabled register (the FD4CE storage cell). It arbitrates between NREQ requesters, grants one at a time, and drives the register's clock enable and data inputs from the granted requester. Grants can be held for a locked burst of at most MAX_HOLD cycles. It sits directly in front of the register, and its CE and D outputs connect straight to the register's CE and D0..D3 pins.

---
 rtl/fd4_write_arbiter_if.sv | 22 ++
 rtl/fd4_write_arbiter.sv | 101 ++++++++++
 tb/tb_fd4_write_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/fd4_write_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : fd4_write_arbiter_if
// Brief  : Requester-side write bus of the FD4 write arbiter.
// Rev    : 1.0
// ---------------------------------------------------------------------------
interface fd4_write_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 4
);
    logic [NREQ-1:0]   REQ;
    logic [NREQ-1:0]   LOCK;
    logic [NREQ*W-1:0] D_IN;
    logic [NREQ-1:0]   GNT;
    logic              CE;
    logic [W-1:0]      D;
    logic              BUSY;

    modport master (output REQ, LOCK, D_IN, input GNT, CE, D, BUSY);
    modport slave  (input REQ, LOCK, D_IN, output GNT, CE, D, BUSY);
endinterface
`default_nettype wire

// File: rtl/fd4_write_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : fd4_write_arbiter
// Brief  : Round-robin write arbiter with bounded locked bursts driving the
//          CE/D pins of a 4-bit register. FD4ARB_FIXED_PRIO_EN selects fixed
//          lowest-index priority instead of round-robin.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module fd4_write_arbiter #(
    parameter int NREQ     = 4,
    parameter int W        = 4,
    parameter int MAX_HOLD = 8
) (
    input  wire logic              C,
    input  wire logic              CLR_N,
    fd4_write_arbiter_if.slave     bus
);
    localparam int              c_pw        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [c_pw-1:0] c_last      = c_pw'(NREQ - 1);
    localparam logic [7:0]      c_hold_last = 8'(MAX_HOLD - 1);
    localparam logic [NREQ-1:0] c_one       = NREQ'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t          r_state;
    logic [NREQ-1:0] r_gnt;
    logic [c_pw-1:0] r_gidx;
    logic [c_pw-1:0] r_ptr;
    logic [7:0]      r_hcnt;

    logic            w_any;
    logic [c_pw-1:0] w_win;
    logic            w_release;
    logic            w_take;
    logic            w_drop;
    logic [W-1:0]    w_d;

    // Search starts one past r_ptr; with r_ptr pinned at NREQ-1 this is
    // plain lowest-index-first, which is how fixed priority falls out.
    always_comb begin : p_search
        int              s;
        logic [c_pw-1:0] idx;
        w_any = 1'b0;
        w_win = '0;
        for (int k = 1; k <= NREQ; k++) begin
            s = int'(r_ptr) + k;
            if (s >= NREQ) begin
                s = s - NREQ;
            end
            idx = c_pw'(s);
            if (!w_any && bus.REQ[idx]) begin
                w_any = 1'b1;
                w_win = idx;
            end
        end
    end

    assign w_release = !bus.REQ[r_gidx] || !bus.LOCK[r_gidx] || (r_hcnt == c_hold_last);
    assign w_take    = w_any && ((r_state == ST_IDLE) || w_release);
    assign w_drop    = (r_state == ST_GRANT) && w_release && !w_any;

    always_ff @(posedge C) begin
        if (!CLR_N) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_gidx  <= c_last;
            r_ptr   <= c_last;
            r_hcnt  <= '0;
        end else if (w_take) begin
            r_state <= ST_GRANT;
            r_gnt   <= c_one << w_win;
            r_gidx  <= w_win;
            r_hcnt  <= '0;
`ifndef FD4ARB_FIXED_PRIO_EN
            r_ptr   <= w_win;
`endif
        end else if (w_drop) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_hcnt  <= '0;
        end else if (r_state == ST_GRANT) begin
            r_hcnt  <= r_hcnt + 8'd1;
        end
    end

    always_comb begin : p_dmux
        w_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_d = w_d | (bus.D_IN[i*W +: W] & {W{r_gnt[i]}});
        end
    end

    assign bus.GNT  = r_gnt;
    assign bus.CE   = |(r_gnt & bus.REQ);
    assign bus.D    = w_d;
    assign bus.BUSY = |r_gnt;
endmodule
`default_nettype wire

// File: tb/tb_fd4_write_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_fd4_write_arbiter
// Brief  : Scoreboard bench for fd4_write_arbiter against a priority-list model.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module tb_fd4_write_arbiter;
    localparam int NREQ     = 4;
    localparam int W        = 4;
    localparam int MAX_HOLD = 8;

    typedef struct packed {
        logic [NREQ-1:0] gnt;
        logic            ce;
        logic [W-1:0]    d;
        logic            busy;
    } exp_t;

    logic C;
    logic CLR_N;

    fd4_write_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

    fd4_write_arbiter #(.NREQ(NREQ), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
        .C     (C),
        .CLR_N (CLR_N),
        .bus   (bus.slave)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    int errors = 0;
    int checks = 0;
    exp_t exp_q[$];

    // Bench copies of what is being driven
    logic              cur_clr;
    logic [NREQ-1:0]   cur_req;
    logic [NREQ-1:0]   cur_lock;
    logic [NREQ*W-1:0] cur_din;

    // Reference model: priority list (front = highest), current grantee, cycles held
    int mg = -1;
    int held = 0;
    int order[$];

    task automatic pick();
        int w;
        w = -1;
        foreach (order[j]) begin
            if (w < 0 && cur_req[order[j]]) w = order[j];
        end
        mg = w;
        held = 1;
`ifndef FD4ARB_FIXED_PRIO_EN
        while (order[0] != w) order.push_back(order.pop_front());
        order.push_back(order.pop_front());
`endif
    endtask

    task automatic model_edge();
        if (!cur_clr) begin
            mg = -1;
            held = 0;
            order.delete();
            for (int i = 0; i < NREQ; i++) order.push_back(i);
        end else if (mg < 0) begin
            if (cur_req != '0) pick();
        end else if (cur_req[mg] && cur_lock[mg] && held < MAX_HOLD) begin
            held++;
        end else if (cur_req != '0) begin
            pick();
        end else begin
            mg = -1;
            held = 0;
        end
    endtask

    task automatic push_expected();
        exp_t e;
        e.gnt  = '0;
        e.ce   = 1'b0;
        e.d    = '0;
        e.busy = 1'b0;
        if (mg >= 0) begin
            e.gnt[mg] = 1'b1;
            e.ce      = cur_req[mg];
            e.d       = cur_din[mg*W +: W];
            e.busy    = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input logic clr, input logic [NREQ-1:0] r,
                        input logic [NREQ-1:0] l, input logic [NREQ*W-1:0] din);
        @(posedge C);
        model_edge();
        #1;
        cur_clr  = clr;
        cur_req  = r;
        cur_lock = l;
        cur_din  = din;
        CLR_N    = clr;
        bus.REQ  = r;
        bus.LOCK = l;
        bus.D_IN = din;
        push_expected();
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle
    always @(negedge C) begin
        exp_t e;
        exp_t a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.GNT, bus.CE, bus.D, bus.BUSY};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs t=%0t: got gnt=%b ce=%b d=%h busy=%b, want gnt=%b ce=%b d=%h busy=%b",
                         $time, a.gnt, a.ce, a.d, a.busy, e.gnt, e.ce, e.d, e.busy);
            end
        end
    end

    localparam logic [NREQ*W-1:0] c_din_seq = 16'h4321;

    initial begin
        logic [31:0] rnd;
        logic [31:0] rnd2;
        logic [NREQ-1:0] r;
        cur_clr = 1'b0; cur_req = '0; cur_lock = '0; cur_din = '0;
        CLR_N = 1'b0; bus.REQ = '0; bus.LOCK = '0; bus.D_IN = '0;

        // Reset held with all requests up, then release
        repeat (3) step(1'b0, 4'b1111, 4'b0000, c_din_seq);
        // Round-robin with unlocked requests
        repeat (7) step(1'b1, 4'b1111, 4'b0000, c_din_seq);

        // Locked burst against a waiting requester
        step(1'b0, 4'b0000, 4'b0000, c_din_seq);
        repeat (22) step(1'b1, 4'b0101, 4'b0001, c_din_seq);

        // Locked grant of requester 2 whose REQ drops
        step(1'b0, 4'b0000, 4'b0000, c_din_seq);
        repeat (4) step(1'b1, 4'b0100, 4'b0100, c_din_seq);
        repeat (3) step(1'b1, 4'b0001, 4'b0100, c_din_seq);
        step(1'b1, 4'b0100, 4'b0100, c_din_seq);
        repeat (2) step(1'b1, 4'b0000, 4'b0100, c_din_seq);

        // Reset in the middle of a locked burst of requester 3
        step(1'b0, 4'b0000, 4'b0000, c_din_seq);
        repeat (4) step(1'b1, 4'b1000, 4'b1000, c_din_seq);
        step(1'b0, 4'b1000, 4'b1000, c_din_seq);
        repeat (5) step(1'b1, 4'b1010, 4'b0000, c_din_seq);

        // Only requester locked: forced release then immediate re-grant
        repeat (20) step(1'b1, 4'b0010, 4'b0010, c_din_seq);

        // Randomized traffic
        r = '0;
        for (int n = 0; n < 500; n++) begin
            rnd  = $urandom;
            rnd2 = $urandom;
            if (rnd2[3:0] < 4'd5) r = rnd[NREQ-1:0];
            step(($urandom_range(0, 49) != 0), r, rnd[NREQ+7:8] | rnd2[NREQ+7:8], rnd2[31:16]);
        end

        repeat (3) @(posedge C);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
